// File: rtl/stc0_bridge_pkg.sv
// Shared register map and bit positions for the stc0 Wishbone bridge.
package stc0_bridge_pkg;

    // Word register select values (byte address bits [3:2])
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS fields
    localparam int ST_TX_COUNT_LSB = 0;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_FULL      = 16;
    localparam int ST_RX_EMPTY     = 17;
    localparam int ST_RX_OVERFLOW  = 18;
    localparam int ST_TX_DROP      = 19;

    // CTRL fields
    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    // RXDATA marks a valid byte with this bit
    localparam int RXDATA_VLD = 31;

endpackage

// File: rtl/stc0_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module stc0_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/stc0_wb_bridge.sv
// Wishbone slave bridging SoC register accesses to the stc0_core byte
// streams: TX FIFO drains onto ID/IValid, RX FIFO captures ED/EValid.
module stc0_wb_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  ID,
    output logic        IValid,
    input  logic [7:0]  ED,
    input  logic        EValid,
    output logic        irq
);

    import stc0_bridge_pkg::*;

    logic        accept;
    logic        hit;
    logic [1:0]  reg_sel;
    logic        wr_acc;
    logic        rd_acc;
    logic [31:0] rdata;

    logic        tx_en;
    logic        irq_en;
    logic        rx_overflow;
    logic        tx_drop;

    logic        tx_push;
    logic        tx_pop;
    logic [7:0]  tx_dout;
    logic        tx_full;
    logic        tx_empty;
    logic [$clog2(TX_DEPTH):0] tx_count;

    logic        rx_pop;
    logic [7:0]  rx_dout;
    logic        rx_full;
    logic        rx_empty;
    logic [$clog2(RX_DEPTH):0] rx_count;

    logic        ovf_set;
    logic        ovf_clr;
    logic        drop_set;
    logic        drop_clr;
    logic        ctrl_wr;

    assign accept  = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = wbs_adr_i[3:2];
    assign wr_acc  = accept & hit & wbs_we_i;
    assign rd_acc  = accept & hit & ~wbs_we_i;

    assign tx_push  = wr_acc & (reg_sel == REG_TXDATA) & wbs_sel_i[0];
    assign tx_pop   = tx_en & ~tx_empty;
    assign rx_pop   = rd_acc & (reg_sel == REG_RXDATA) & ~rx_empty;
    assign ctrl_wr  = wr_acc & (reg_sel == REG_CTRL) & wbs_sel_i[0];

    // A push into a full FIFO survives only if the same cycle frees a slot
    assign drop_set = tx_push & tx_full & ~tx_pop;
    assign ovf_set  = EValid & rx_full & ~rx_pop;
    assign drop_clr = wr_acc & (reg_sel == REG_STATUS) & wbs_sel_i[2] & wbs_dat_i[ST_TX_DROP];
    assign ovf_clr  = wr_acc & (reg_sel == REG_STATUS) & wbs_sel_i[2] & wbs_dat_i[ST_RX_OVERFLOW];

    stc0_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wbs_dat_i[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    stc0_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (EValid),
        .pop   (rx_pop),
        .din   (ED),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Read mux; misses and write-only registers return zero
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (reg_sel)
                REG_RXDATA: begin
                    if (!rx_empty) begin
                        rdata[RXDATA_VLD] = 1'b1;
                        rdata[7:0]        = rx_dout;
                    end
                end
                REG_STATUS: begin
                    rdata[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
                    rdata[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
                    rdata[ST_TX_FULL]           = tx_full;
                    rdata[ST_RX_EMPTY]          = rx_empty;
                    rdata[ST_RX_OVERFLOW]       = rx_overflow;
                    rdata[ST_TX_DROP]           = tx_drop;
                end
                REG_CTRL: begin
                    rdata[CTRL_TX_EN]  = tx_en;
                    rdata[CTRL_IRQ_EN] = irq_en;
                end
                default: rdata = '0;
            endcase
        end
    end

    // Single-cycle ack with read data presented only during the ack cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= (accept & ~wbs_we_i) ? rdata : '0;
        end
    end

    // Control bits and sticky flags; a set in the same cycle as a clear wins
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_en       <= 1'b0;
            irq_en      <= 1'b0;
            rx_overflow <= 1'b0;
            tx_drop     <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                tx_en  <= wbs_dat_i[CTRL_TX_EN];
                irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            rx_overflow <= ovf_set  | (rx_overflow & ~ovf_clr);
            tx_drop     <= drop_set | (tx_drop & ~drop_clr);
        end
    end

    // Ingress output register: one byte per IValid cycle, ID holds when idle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            IValid <= 1'b0;
            ID     <= '0;
        end else begin
            IValid <= tx_pop;
            if (tx_pop) ID <= tx_dout;
        end
    end

    // Registered level interrupt
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq <= 1'b0;
        else          irq <= irq_en & (~rx_empty | rx_overflow | tx_drop);
    end

endmodule

// File: tb/tb_stc0_wb_bridge.sv
// Directed self-checking bench for stc0_wb_bridge.
module tb_stc0_wb_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_RX = BASE + 32'h4;
    localparam logic [31:0] A_ST = BASE + 32'h8;
    localparam logic [31:0] A_CT = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = '0;
    logic [31:0] adr = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic [7:0]  id;
    logic        ivalid;
    logic [7:0]  ed = '0;
    logic        evalid = 1'b0;
    logic        irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stc0_wb_bridge #(.BASE_ADDR(BASE), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .ID        (id),
        .IValid    (ivalid),
        .ED        (ed),
        .EValid    (evalid),
        .irq       (irq)
    );

    // One bus transfer; starts and ends 1 time unit after a rising edge
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        rd = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL ack_timeout adr=%h got ack=0 want ack=1", a);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] unused;
        wb_xfer(1'b1, a, d, 4'hF, unused);
    endtask

    task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, a, 32'h0, 4'hF, rd);
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, rd, exp);
        end
    endtask

    task automatic rx_push(input logic [7:0] b);
        evalid = 1'b1; ed = b;
        @(posedge clk); #1;
        evalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({ack, ivalid, irq} !== 3'b000 || dat_o !== 32'h0 || id !== 8'h0) begin
            fails++;
            $display("FAIL reset_outputs got ack=%b iv=%b irq=%b dat=%h id=%h want all 0",
                     ack, ivalid, irq, dat_o, id);
        end
        rst = 1'b0;
        check_read("reset_status", A_ST, 32'h0002_0000);
        @(posedge clk); #1;
        tests++;
        if (ack !== 1'b0 || dat_o !== 32'h0) begin
            fails++;
            $display("FAIL ack_single_cycle got ack=%b dat=%h want ack=0 dat=0", ack, dat_o);
        end
        check_read("reset_ctrl", A_CT, 32'h0);
    endtask

    task automatic test_tx_drain;
        wb_write(A_TX, 32'h0000_00A5);
        wb_write(A_TX, 32'h0000_003C);
        check_read("tx_count_2", A_ST, 32'h0002_0002);
        tests++;
        if (ivalid !== 1'b0) begin
            fails++;
            $display("FAIL tx_disabled_idle got IValid=%b want 0", ivalid);
        end
        wb_write(A_CT, 32'h1);
        @(posedge clk); #1;
        tests++;
        if (ivalid !== 1'b1 || id !== 8'hA5) begin
            fails++;
            $display("FAIL tx_byte0 got iv=%b id=%h want iv=1 id=a5", ivalid, id);
        end
        @(posedge clk); #1;
        tests++;
        if (ivalid !== 1'b1 || id !== 8'h3C) begin
            fails++;
            $display("FAIL tx_byte1 got iv=%b id=%h want iv=1 id=3c", ivalid, id);
        end
        @(posedge clk); #1;
        tests++;
        if (ivalid !== 1'b0 || id !== 8'h3C) begin
            fails++;
            $display("FAIL tx_end_hold got iv=%b id=%h want iv=0 id=3c", ivalid, id);
        end
        check_read("tx_count_0", A_ST, 32'h0002_0000);
        // Latency with tx_en already set and FIFO empty
        wb_write(A_TX, 32'h0000_005A);
        tests++;
        if (ivalid !== 1'b0) begin
            fails++;
            $display("FAIL tx_latency_early got IValid=%b want 0", ivalid);
        end
        @(posedge clk); #1;
        tests++;
        if (ivalid !== 1'b1 || id !== 8'h5A) begin
            fails++;
            $display("FAIL tx_latency got iv=%b id=%h want iv=1 id=5a", ivalid, id);
        end
        wb_write(A_CT, 32'h0);
    endtask

    task automatic test_rx_capture;
        evalid = 1'b1; ed = 8'h11;
        @(posedge clk); #1;
        ed = 8'h22;
        @(posedge clk); #1;
        evalid = 1'b0;
        check_read("rx_first", A_RX, 32'h8000_0011);
        check_read("rx_second", A_RX, 32'h8000_0022);
        check_read("rx_empty", A_RX, 32'h0);
    endtask

    task automatic test_rx_overflow;
        for (int i = 0; i < 16; i++) rx_push(8'(8'h40 + i));
        rx_push(8'h99);
        check_read("rx_ovf_status", A_ST, 32'h0004_1000);
        wb_write(A_ST, 32'h0004_0000);
        check_read("rx_ovf_cleared", A_ST, 32'h0000_1000);
        for (int i = 0; i < 16; i++)
            check_read("rx_ovf_readback", A_RX, 32'h8000_0040 + 32'(i));
        check_read("rx_ovf_no_99", A_RX, 32'h0);
    endtask

    task automatic test_full_pop_and_irq;
        for (int i = 0; i < 16; i++) rx_push(8'(8'h60 + i));
        // RXDATA pop and EValid land on the same edge
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_RX; sel = 4'hF;
        evalid = 1'b1; ed = 8'h77;
        @(posedge clk); #1;
        evalid = 1'b0;
        tests++;
        if (ack !== 1'b1 || dat_o !== 32'h8000_0060) begin
            fails++;
            $display("FAIL full_pop_read got ack=%b dat=%h want ack=1 dat=80000060", ack, dat_o);
        end
        stb = 1'b0; cyc = 1'b0;
        check_read("full_pop_status", A_ST, 32'h0000_1000);
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_masked got irq=%b want 0", irq);
        end
        wb_write(A_CT, 32'h2);
        @(posedge clk); #1;
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_rx_data got irq=%b want 1", irq);
        end
        for (int i = 1; i < 16; i++)
            check_read("full_pop_drain", A_RX, 32'h8000_0060 + 32'(i));
        check_read("full_pop_last", A_RX, 32'h8000_0077);
        check_read("full_pop_empty", A_RX, 32'h0);
        @(posedge clk); #1;
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_drained got irq=%b want 0", irq);
        end
    endtask

    task automatic test_tx_drop;
        for (int i = 0; i < 17; i++) wb_write(A_TX, 32'(8'h80 + i));
        check_read("tx_drop_status", A_ST, 32'h000B_0010);
        @(posedge clk); #1;
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_tx_drop got irq=%b want 1", irq);
        end
        wb_write(A_ST, 32'h0008_0000);
        check_read("tx_drop_cleared", A_ST, 32'h0003_0010);
    endtask

    task automatic test_reset_mid;
        wb_write(A_CT, 32'h1);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = A_TX; dat_i = 32'hEE; sel = 4'hF;
        @(posedge clk); #1;
        tests++;
        if (ack !== 1'b1 || ivalid !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_busy got ack=%b iv=%b want ack=1 iv=1", ack, ivalid);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (ack !== 1'b0 || ivalid !== 1'b0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got ack=%b iv=%b irq=%b want 0 0 0", ack, ivalid, irq);
        end
        rst = 1'b0;
        check_read("post_reset_status", A_ST, 32'h0002_0000);
        check_read("post_reset_ctrl", A_CT, 32'h0);
        wb_write(BASE + 32'h10, 32'h3);
        check_read("miss_read", BASE + 32'h10, 32'h0);
        check_read("miss_no_effect", A_CT, 32'h0);
    endtask

    initial begin
        #1;
        test_reset;
        test_tx_drain;
        test_rx_capture;
        test_rx_overflow;
        test_full_pop_and_irq;
        test_tx_drop;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stc0_wb_bridge.md
Name: stc0_wb_bridge

Overview:
- Wishbone slave that lets the management SoC drive the stc0_core byte-stream interface directly, instead of going through GPIO pins.
- Upstream side: writes push bytes into a TX FIFO, which drains onto ID/IValid.
- Downstream side: bytes on ED/EValid are captured into an RX FIFO, which software reads.
- Sits in user_project_wrapper between the Wishbone port and stc0_core; one clock domain, stc0_core clocked from wb_clk_i in this configuration.

Parameters:
- BASE_ADDR, 32'h3000_0000, register window base; window is 16 bytes, 4 word registers.
- TX_DEPTH, 16, TX FIFO entries; power of two, 2..128.
- RX_DEPTH, 16, RX FIFO entries; power of two, 2..128.

Ports:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- ID  out  8  ingress byte to stc0_core.
- IValid  out  1  ingress byte valid; one byte per high cycle.
- ED  in  8  egress byte from stc0_core.
- EValid  in  1  egress byte valid.
- irq  out  1  level interrupt.

Behaviour:
- Reset:
  - wbs_ack_o=0, wbs_dat_o=0, ID=0, IValid=0, irq=0.
  - Both FIFOs empty; CTRL=0; sticky flags cleared.
  - Reset asserted mid-transfer drops any pending ack and in-flight IValid on the next edge.
- Request acceptance:
  - A request is accepted at edge k when stb & cyc & !wbs_ack_o.
  - wbs_ack_o is high for exactly cycle k+1; wbs_dat_o is valid in that cycle and 0 otherwise.
  - Back-to-back requests are therefore serviced at most every 2 cycles.
- Address decode:
  - hit = adr[31:4]==BASE_ADDR[31:4]; register select = adr[3:2].
  - A miss is still acked, with read data 0 and no side effects.
- Registers:
  - 0x0 TXDATA (W): if sel[0], push dat_i[7:0].
    - If the TX FIFO is full, the byte is dropped and tx_drop is set.
    - Reads return 0.
  - 0x4 RXDATA (R): if not empty, return {1'b1, 23'b0, head} and pop.
    - If empty, return 0 and do not pop.
    - Writes are ignored.
  - 0x8 STATUS:
    - [7:0] tx_count, [15:8] rx_count, [16] tx_full, [17] rx_empty, [18] rx_overflow, [19] tx_drop.
    - Writing 1 to bit 18 or bit 19 clears that flag (W1C, gated by sel[2]).
  - 0xC CTRL (R/W, gated by sel[0]): [0] tx_en, [1] irq_en; other bits read 0.
- TX drain:
  - Each cycle where tx_en=1 and the TX FIFO is non-empty, pop the head into the output register.
  - Next cycle: IValid=1 and ID=byte. Otherwise IValid=0; ID holds its last value.
  - Back-to-back bytes produce continuous IValid.
  - Byte pushed at edge k with tx_en=1 and FIFO empty: IValid high in cycle k+2.
  - Clearing tx_en stops further pops; a byte already in the output register still emits.
- RX capture:
  - EValid=1 pushes ED at that edge.
  - If the RX FIFO is full, the byte is dropped and rx_overflow is set (sticky).
  - Push and pop in the same cycle is legal on either FIFO: count unchanged, data order preserved.
  - A push into a full RX FIFO in the same cycle as an RXDATA pop is accepted, not dropped.
- A W1C clear coincident with a new set event leaves the flag set.
- irq is registered: irq = irq_en & (!rx_empty | rx_overflow | tx_drop).
- Counts saturate naturally at DEPTH; pointers are log2(DEPTH) bits and wrap modulo DEPTH.

Decomposition:
- Package stc0_bridge_pkg holds:
  - register offsets REG_TXDATA/REG_RXDATA/REG_STATUS/REG_CTRL;
  - STATUS bit indices;
  - CTRL bit indices;
  - RXDATA valid bit index (31).
- One sub-module, stc0_sync_fifo, instantiated twice (TX and RX).
  - Parameters: WIDTH and DEPTH.
  - Ports: push/pop/din/dout/full/empty/count.
  - Synchronous active-high reset; first-word-fall-through head.

Test Plan:
1. Reset, then read STATUS -> 0x0002_0000 (rx_empty only); read CTRL -> 0; IValid=0, irq=0.
2. tx_en=0; write TXDATA 0xA5, 0x3C; set CTRL=1 -> IValid high two consecutive cycles with ID=0xA5, then 0x3C; STATUS tx_count returns 0.
3. Pulse EValid with ED=0x11,0x22 -> RXDATA reads return 0x8000_0011, then 0x8000_0022, then 0x0000_0000.
4. Push RX_DEPTH+1 bytes via EValid (16 then 0x99) -> rx_count=16, rx_overflow=1, 0x99 absent on readback; write STATUS 0x0004_0000 -> overflow cleared.
5. RX full with EValid coincident with the RXDATA-pop edge -> no overflow, rx_count stays 16; CTRL=2 with data present -> irq=1, clears after draining.
6. Assert wb_rst_i during a TXDATA ack cycle and during an IValid burst -> next cycle ack=0, IValid=0, FIFOs empty; access to BASE_ADDR+0x10 -> acked, reads 0.
